// File: rtl/axil_pkg.sv
// Shared constants, FSM state types and helpers for the AXI4-Lite OCM responder.
package axil_pkg;

    localparam int unsigned RESP_W = 2;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = (v > 0) ? v - 1 : 0;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/axil_ocm_responder_if.sv
// AXI4-Lite bus bundle between the PS master port and the OCM responder.
interface axil_ocm_responder_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] S_AXI_AWADDR;
    logic [2:0]        S_AXI_AWPROT;
    logic              S_AXI_AWVALID;
    logic              S_AXI_AWREADY;
    logic [DATA_W-1:0] S_AXI_WDATA;
    logic [STRB_W-1:0] S_AXI_WSTRB;
    logic              S_AXI_WVALID;
    logic              S_AXI_WREADY;
    logic [1:0]        S_AXI_BRESP;
    logic              S_AXI_BVALID;
    logic              S_AXI_BREADY;
    logic [ADDR_W-1:0] S_AXI_ARADDR;
    logic [2:0]        S_AXI_ARPROT;
    logic              S_AXI_ARVALID;
    logic              S_AXI_ARREADY;
    logic [DATA_W-1:0] S_AXI_RDATA;
    logic [1:0]        S_AXI_RRESP;
    logic              S_AXI_RVALID;
    logic              S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

endinterface

// File: rtl/axil_ram_1w1r.sv
// Word memory with one byte-enabled write port and one registered read port.
// A read and write to the same word on one edge returns the pre-write data.
module axil_ram_1w1r
    import axil_pkg::*;
#(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [clog2(DEPTH)-1:0]   wr_idx,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic [DATA_W/8-1:0]       wr_strb,
    input  logic                      rd_en,
    input  logic [clog2(DEPTH)-1:0]   rd_idx,
    output logic [DATA_W-1:0]         rd_data
);

    localparam int unsigned STRB_W = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    // Nonblocking update gives read-old-data on a same-word collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (wr_en) begin
                for (int b = 0; b < int'(STRB_W); b++) begin
                    if (wr_strb[b]) begin
                        mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                    end
                end
            end
            if (rd_en) begin
                rd_data <= mem[rd_idx];
            end
        end
    end

endmodule

// File: rtl/axil_ocm_responder.sv
// AXI4-Lite slave answering single-beat PS reads/writes from a PL word memory.
// Word 0 low bits (LED_W <= 8) mirror onto the board LEDs.
module axil_ocm_responder
    import axil_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned LED_W  = 4
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    axil_ocm_responder_if.slave  s_axi,
    output logic [LED_W-1:0]     leds
);

    localparam int unsigned IDX_W  = clog2(DEPTH);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned LIMIT  = DEPTH * 4;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < 32'(LIMIT);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return a[2 +: IDX_W];
    endfunction

    // Protection attributes carry no meaning for this responder.
    logic unused_prot;
    assign unused_prot = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT};

    // ---------------- write channel ----------------
    w_state_e          w_state_q, w_state_d;
    logic              aw_held_q, aw_held_d;
    logic              w_held_q,  w_held_d;
    logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
    logic [DATA_W-1:0] w_data_q,  w_data_d;
    logic [STRB_W-1:0] w_strb_q,  w_strb_d;
    logic              awready_q, awready_d;
    logic              wready_q,  wready_d;
    logic              bvalid_q,  bvalid_d;
    logic [RESP_W-1:0] bresp_q,   bresp_d;
    logic [LED_W-1:0]  leds_q,    leds_d;

    logic              aw_hs, w_hs;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_data;
    logic [STRB_W-1:0] cur_strb;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            leds_q    <= '0;
        end else begin
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            aw_addr_q <= aw_addr_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            leds_q    <= leds_d;
        end
    end

    // AW and W are captured independently; commit on the edge both are known.
    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        aw_addr_d = aw_addr_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        leds_d    = leds_q;
        wr_en     = 1'b0;

        aw_hs    = s_axi.S_AXI_AWVALID && awready_q;
        w_hs     = s_axi.S_AXI_WVALID  && wready_q;
        cur_addr = aw_held_q ? aw_addr_q : s_axi.S_AXI_AWADDR;
        cur_data = w_held_q  ? w_data_q  : s_axi.S_AXI_WDATA;
        cur_strb = w_held_q  ? w_strb_q  : s_axi.S_AXI_WSTRB;
        wr_idx   = word_idx(cur_addr);

        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    aw_addr_d = s_axi.S_AXI_AWADDR;
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    w_data_d = s_axi.S_AXI_WDATA;
                    w_strb_d = s_axi.S_AXI_WSTRB;
                end
                awready_d = !(aw_held_q || aw_hs);
                wready_d  = !(w_held_q  || w_hs);
                if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    w_state_d = W_RESP;
                    if (in_range(cur_addr)) begin
                        bresp_d = RESP_OKAY;
                        wr_en   = 1'b1;
                        if (wr_idx == '0 && cur_strb[0]) begin
                            leds_d = cur_data[LED_W-1:0];
                        end
                    end else begin
                        bresp_d = RESP_SLVERR;
                    end
                end
            end
            W_RESP: begin
                if (s_axi.S_AXI_BREADY) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // ---------------- read channel ----------------
    r_state_e          r_state_q, r_state_d;
    logic              arready_q, arready_d;
    logic              rvalid_q,  rvalid_d;
    logic [RESP_W-1:0] rresp_q,   rresp_d;
    logic              rd_ok_q,   rd_ok_d;
    logic              ar_hs;
    logic              rd_en;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] ram_rdata;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rd_ok_q   <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rd_ok_q   <= rd_ok_d;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rd_ok_d   = rd_ok_q;
        rd_en     = 1'b0;

        ar_hs  = s_axi.S_AXI_ARVALID && arready_q;
        rd_idx = word_idx(s_axi.S_AXI_ARADDR);

        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    r_state_d = R_DATA;
                    rd_ok_d   = in_range(s_axi.S_AXI_ARADDR);
                    rd_en     = rd_ok_d;
                    rresp_d   = rd_ok_d ? RESP_OKAY : RESP_SLVERR;
                end
            end
            R_DATA: begin
                if (s_axi.S_AXI_RREADY) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    axil_ram_1w1r #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (ACLK),
        .rst_n   (ARESETn),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (cur_data),
        .wr_strb (cur_strb),
        .rd_en   (rd_en),
        .rd_idx  (rd_idx),
        .rd_data (ram_rdata)
    );

    assign s_axi.S_AXI_AWREADY = awready_q;
    assign s_axi.S_AXI_WREADY  = wready_q;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_ARREADY = arready_q;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RRESP   = rresp_q;
    // Out-of-range reads never touch the RAM; the held flag forces zero data.
    assign s_axi.S_AXI_RDATA   = rd_ok_q ? ram_rdata : '0;
    assign leds                = leds_q;

endmodule

// File: tb/tb_axil_ocm_responder.sv
// Directed bench for axil_ocm_responder: channel handshakes, strobes, decode,
// collision ordering, backpressure and mid-transaction reset.
module tb_axil_ocm_responder;

    logic       tb_ACLK;
    logic       tb_ARESETn;
    logic [3:0] leds;

    int vec_cnt;
    int err_cnt;

    axil_ocm_responder_if #(.ADDR_W(16), .DATA_W(32)) bus ();

    axil_ocm_responder #(
        .ADDR_W (16),
        .DATA_W (32),
        .DEPTH  (1024),
        .LED_W  (4)
    ) dut (
        .ACLK    (tb_ACLK),
        .ARESETn (tb_ARESETn),
        .s_axi   (bus),
        .leds    (leds)
    );

    initial tb_ACLK = 1'b0;
    always #5 tb_ACLK = ~tb_ACLK;

    task automatic idle_inputs();
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA = '0;  bus.S_AXI_WSTRB = '0;  bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY = 1'b0;
    endtask

    // Full write: AW+W together, then accept B. Timeouts count as miscompares.
    task automatic axi_write(input logic [15:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
        bit aw_done, w_done, aw_fire, w_fire;
        int n;
        resp = 2'bxx;
        @(negedge tb_ACLK);
        bus.S_AXI_AWADDR = a; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA = d;  bus.S_AXI_WSTRB = s; bus.S_AXI_WVALID = 1'b1;
        aw_done = 0; w_done = 0; n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            aw_fire = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
            w_fire  = bus.S_AXI_WVALID  && bus.S_AXI_WREADY;
            @(negedge tb_ACLK);
            if (aw_fire) begin bus.S_AXI_AWVALID = 1'b0; aw_done = 1; end
            if (w_fire)  begin bus.S_AXI_WVALID  = 1'b0; w_done  = 1; end
            n++;
        end
        n = 0;
        while (!bus.S_AXI_BVALID && n < 20) begin @(negedge tb_ACLK); n++; end
        if (!bus.S_AXI_BVALID) begin
            vec_cnt++; err_cnt++;
            $display("FAIL write_timeout: addr %h got no BVALID within 20 cycles", a);
            idle_inputs();
            return;
        end
        resp = bus.S_AXI_BRESP;
        bus.S_AXI_BREADY = 1'b1;
        @(negedge tb_ACLK);
        bus.S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [15:0] a, output logic [31:0] d,
                            output logic [1:0] resp);
        int n;
        d = 'x; resp = 2'bxx;
        @(negedge tb_ACLK);
        bus.S_AXI_ARADDR = a; bus.S_AXI_ARVALID = 1'b1;
        n = 0;
        while (!bus.S_AXI_ARREADY && n < 20) begin @(negedge tb_ACLK); n++; end
        @(negedge tb_ACLK);
        bus.S_AXI_ARVALID = 1'b0;
        n = 0;
        while (!bus.S_AXI_RVALID && n < 20) begin @(negedge tb_ACLK); n++; end
        if (!bus.S_AXI_RVALID) begin
            vec_cnt++; err_cnt++;
            $display("FAIL read_timeout: addr %h got no RVALID within 20 cycles", a);
            idle_inputs();
            return;
        end
        d = bus.S_AXI_RDATA; resp = bus.S_AXI_RRESP;
        bus.S_AXI_RREADY = 1'b1;
        @(negedge tb_ACLK);
        bus.S_AXI_RREADY = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        tb_ARESETn = 1'b0;
        repeat (3) @(negedge tb_ACLK);
        vec_cnt++; if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 3'b000) begin
            err_cnt++; $display("FAIL reset_ready: got %b want 000", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}); end
        vec_cnt++; if ({bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_BRESP, bus.S_AXI_RRESP} !== 6'b0) begin
            err_cnt++; $display("FAIL reset_valid_resp: got %b want 000000", {bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_BRESP, bus.S_AXI_RRESP}); end
        vec_cnt++; if (bus.S_AXI_RDATA !== 32'h0 || leds !== 4'h0) begin
            err_cnt++; $display("FAIL reset_rdata_leds: got %h/%h want 00000000/0", bus.S_AXI_RDATA, leds); end
        tb_ARESETn = 1'b1;
        @(negedge tb_ACLK);
        vec_cnt++; if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 3'b111) begin
            err_cnt++; $display("FAIL ready_after_reset: got %b want 111", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}); end
    endtask

    task automatic test_full_word();
        logic [1:0] br, rr; logic [31:0] rd;
        axi_write(16'h0000, 32'hDEADBEEF, 4'hF, br);
        vec_cnt++; if (br !== 2'b00) begin err_cnt++; $display("FAIL full_bresp: got %b want 00", br); end
        vec_cnt++; if (leds !== 4'hF) begin err_cnt++; $display("FAIL full_leds: got %h want f", leds); end
        axi_read(16'h0000, rd, rr);
        vec_cnt++; if (rd !== 32'hDEADBEEF || rr !== 2'b00) begin
            err_cnt++; $display("FAIL full_read: got %h/%b want deadbeef/00", rd, rr); end
    endtask

    task automatic test_strobes();
        logic [1:0] br, rr; logic [31:0] rd;
        axi_write(16'h0004, 32'hDEADBEEF, 4'hF, br);
        axi_write(16'h0004, 32'h00001234, 4'b0011, br);
        vec_cnt++; if (br !== 2'b00) begin err_cnt++; $display("FAIL strb_bresp: got %b want 00", br); end
        axi_read(16'h0004, rd, rr);
        vec_cnt++; if (rd !== 32'hDEAD1234) begin err_cnt++; $display("FAIL strb_merge: got %h want dead1234", rd); end
        axi_write(16'h0006, 32'hFFFFFFFF, 4'b0000, br);
        vec_cnt++; if (br !== 2'b00) begin err_cnt++; $display("FAIL strb_zero_bresp: got %b want 00", br); end
        axi_read(16'h0007, rd, rr);
        vec_cnt++; if (rd !== 32'hDEAD1234) begin err_cnt++; $display("FAIL strb_zero_noop: got %h want dead1234", rd); end
    endtask

    task automatic test_w_before_aw();
        logic [1:0] rr; logic [31:0] rd;
        @(negedge tb_ACLK);
        bus.S_AXI_WDATA = 32'hA5A5A5A5; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        vec_cnt++; if (bus.S_AXI_WREADY !== 1'b1) begin err_cnt++; $display("FAIL wfirst_wready_hi: got %b want 1", bus.S_AXI_WREADY); end
        @(negedge tb_ACLK);
        bus.S_AXI_WVALID = 1'b0;
        vec_cnt++; if ({bus.S_AXI_WREADY, bus.S_AXI_AWREADY} !== 2'b01) begin
            err_cnt++; $display("FAIL wfirst_wready_drop: got wr/awr %b want 01", {bus.S_AXI_WREADY, bus.S_AXI_AWREADY}); end
        repeat (2) @(negedge tb_ACLK);
        vec_cnt++; if (bus.S_AXI_BVALID !== 1'b0) begin err_cnt++; $display("FAIL wfirst_no_early_b: got %b want 0", bus.S_AXI_BVALID); end
        bus.S_AXI_AWADDR = 16'h0008; bus.S_AXI_AWVALID = 1'b1;
        @(negedge tb_ACLK);
        bus.S_AXI_AWVALID = 1'b0;
        vec_cnt++; if (bus.S_AXI_BVALID !== 1'b1 || bus.S_AXI_BRESP !== 2'b00) begin
            err_cnt++; $display("FAIL wfirst_b_latency: got bvalid %b bresp %b want 1/00", bus.S_AXI_BVALID, bus.S_AXI_BRESP); end
        bus.S_AXI_BREADY = 1'b1;
        @(negedge tb_ACLK);
        bus.S_AXI_BREADY = 1'b0;
        axi_read(16'h0008, rd, rr);
        vec_cnt++; if (rd !== 32'hA5A5A5A5) begin err_cnt++; $display("FAIL wfirst_read: got %h want a5a5a5a5", rd); end
    endtask

    task automatic test_out_of_range();
        logic [1:0] br, rr; logic [31:0] rd;
        axi_write(16'h1000, 32'h12345670, 4'hF, br);
        vec_cnt++; if (br !== 2'b10) begin err_cnt++; $display("FAIL oor_bresp: got %b want 10", br); end
        axi_read(16'h1000, rd, rr);
        vec_cnt++; if (rd !== 32'h0 || rr !== 2'b10) begin err_cnt++; $display("FAIL oor_read: got %h/%b want 00000000/10", rd, rr); end
        axi_read(16'h0000, rd, rr);
        vec_cnt++; if (rd !== 32'hDEADBEEF || leds !== 4'hF) begin
            err_cnt++; $display("FAIL oor_no_alias: got word0 %h leds %h want deadbeef/f", rd, leds); end
        axi_read(16'hFFFC, rd, rr);
        vec_cnt++; if (rr !== 2'b10) begin err_cnt++; $display("FAIL oor_top_rresp: got %b want 10", rr); end
        axi_read(16'h0FFC, rd, rr);
        vec_cnt++; if (rd !== 32'h0 || rr !== 2'b00) begin err_cnt++; $display("FAIL last_word_read: got %h/%b want 00000000/00", rd, rr); end
    endtask

    task automatic test_backpressure();
        @(negedge tb_ACLK);
        bus.S_AXI_AWADDR = 16'h000C; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA = 32'h0BADF00D; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        @(negedge tb_ACLK);
        bus.S_AXI_WDATA = 32'h0;
        bus.S_AXI_AWADDR = 16'h0010;
        for (int i = 0; i < 5; i++) begin
            vec_cnt++; if ({bus.S_AXI_BVALID, bus.S_AXI_BRESP, bus.S_AXI_AWREADY, bus.S_AXI_WREADY} !== 5'b10000) begin
                err_cnt++; $display("FAIL bp_write cyc%0d: got bv/br/awr/wr %b want 10000", i, {bus.S_AXI_BVALID, bus.S_AXI_BRESP, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}); end
            @(negedge tb_ACLK);
        end
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_BREADY = 1'b1;
        @(negedge tb_ACLK);
        bus.S_AXI_BREADY = 1'b0;
        vec_cnt++; if ({bus.S_AXI_BVALID, bus.S_AXI_AWREADY} !== 2'b01) begin
            err_cnt++; $display("FAIL bp_write_release: got bv/awr %b want 01", {bus.S_AXI_BVALID, bus.S_AXI_AWREADY}); end
        bus.S_AXI_ARADDR = 16'h000C; bus.S_AXI_ARVALID = 1'b1;
        @(negedge tb_ACLK);
        bus.S_AXI_ARADDR = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            vec_cnt++; if ({bus.S_AXI_RVALID, bus.S_AXI_ARREADY, bus.S_AXI_RRESP} !== 4'b1000 || bus.S_AXI_RDATA !== 32'h0BADF00D) begin
                err_cnt++; $display("FAIL bp_read cyc%0d: got rv/arr/rr %b data %h want 1000/0badf00d", i, {bus.S_AXI_RVALID, bus.S_AXI_ARREADY, bus.S_AXI_RRESP}, bus.S_AXI_RDATA); end
            @(negedge tb_ACLK);
        end
        bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY = 1'b1;
        @(negedge tb_ACLK);
        bus.S_AXI_RREADY = 1'b0;
        vec_cnt++; if ({bus.S_AXI_RVALID, bus.S_AXI_ARREADY} !== 2'b01) begin
            err_cnt++; $display("FAIL bp_read_release: got rv/arr %b want 01", {bus.S_AXI_RVALID, bus.S_AXI_ARREADY}); end
    endtask

    task automatic test_collision();
        logic [1:0] rr; logic [31:0] rd;
        @(negedge tb_ACLK);
        bus.S_AXI_AWADDR = 16'h0000; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA = 32'hCAFEF00D; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        bus.S_AXI_ARADDR = 16'h0000; bus.S_AXI_ARVALID = 1'b1;
        @(negedge tb_ACLK);
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
        vec_cnt++; if (bus.S_AXI_RVALID !== 1'b1 || bus.S_AXI_RDATA !== 32'hDEADBEEF) begin
            err_cnt++; $display("FAIL collide_old_data: got rv %b data %h want 1/deadbeef", bus.S_AXI_RVALID, bus.S_AXI_RDATA); end
        vec_cnt++; if (bus.S_AXI_BVALID !== 1'b1 || leds !== 4'hD) begin
            err_cnt++; $display("FAIL collide_write: got bv %b leds %h want 1/d", bus.S_AXI_BVALID, leds); end
        bus.S_AXI_BREADY = 1'b1; bus.S_AXI_RREADY = 1'b1;
        @(negedge tb_ACLK);
        bus.S_AXI_BREADY = 1'b0; bus.S_AXI_RREADY = 1'b0;
        axi_read(16'h0000, rd, rr);
        vec_cnt++; if (rd !== 32'hCAFEF00D) begin err_cnt++; $display("FAIL collide_new_data: got %h want cafef00d", rd); end
    endtask

    task automatic test_reset_mid();
        logic [1:0] rr; logic [31:0] rd;
        @(negedge tb_ACLK);
        bus.S_AXI_AWADDR = 16'h0010; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA = 32'h00000055; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        @(negedge tb_ACLK);
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        vec_cnt++; if (bus.S_AXI_BVALID !== 1'b1) begin err_cnt++; $display("FAIL mid_wresp_entry: got %b want 1", bus.S_AXI_BVALID); end
        #1 tb_ARESETn = 1'b0;
        #1;
        vec_cnt++; if ({bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 4'b0 || leds !== 4'h0) begin
            err_cnt++; $display("FAIL mid_wresp_reset: got bv/awr/wr/arr %b leds %h want 0000/0", {bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, leds); end
        @(negedge tb_ACLK);
        tb_ARESETn = 1'b1;
        @(negedge tb_ACLK);
        bus.S_AXI_ARADDR = 16'h0000; bus.S_AXI_ARVALID = 1'b1;
        @(negedge tb_ACLK);
        bus.S_AXI_ARVALID = 1'b0;
        vec_cnt++; if (bus.S_AXI_RVALID !== 1'b1) begin err_cnt++; $display("FAIL mid_rdata_entry: got %b want 1", bus.S_AXI_RVALID); end
        #1 tb_ARESETn = 1'b0;
        #1;
        vec_cnt++; if ({bus.S_AXI_RVALID, bus.S_AXI_ARREADY, bus.S_AXI_BVALID} !== 3'b0 || bus.S_AXI_RDATA !== 32'h0) begin
            err_cnt++; $display("FAIL mid_rdata_reset: got rv/arr/bv %b data %h want 000/00000000", {bus.S_AXI_RVALID, bus.S_AXI_ARREADY, bus.S_AXI_BVALID}, bus.S_AXI_RDATA); end
        @(negedge tb_ACLK);
        tb_ARESETn = 1'b1;
        @(negedge tb_ACLK);
        axi_read(16'h0000, rd, rr);
        vec_cnt++; if (rd !== 32'h0 || rr !== 2'b00) begin err_cnt++; $display("FAIL mid_word0_cleared: got %h/%b want 00000000/00", rd, rr); end
        axi_read(16'h0010, rd, rr);
        vec_cnt++; if (rd !== 32'h0) begin err_cnt++; $display("FAIL mid_word4_cleared: got %h want 00000000", rd); end
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        tb_ARESETn = 1'b0;
        idle_inputs();
        test_reset();
        test_full_word();
        test_strobes();
        test_w_before_aw();
        test_out_of_range();
        test_backpressure();
        test_collision();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    // Global watchdog so a stuck handshake can never hang the run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 time units");
        $fatal(1, "watchdog");
    end

endmodule
